// File: rtl/mem_byte_seq_ctrl_pkg.sv
// Shared types and helpers for the byte-serialising memory controller.
// Size codes follow the RV32I funct3 low bits; code 2'b11 behaves as a word.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    case (sz)
      SZ_BYTE: return {{24{raw[7] & ~uns}}, raw[7:0]};
      SZ_HALF: return {{16{raw[15] & ~uns}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_seq_ctrl_if.sv
// Fetch port, data port and byte-bank signals of the shared memory controller.
// The slave modport is the controller's view; master is the surrounding core/bank.
interface mem_byte_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  if_valid_i;
  logic                  if_ready_o;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_rvalid_o;
  logic [31:0]           if_rdata_o;

  logic                  d_valid_i;
  logic                  d_ready_o;
  logic                  d_we_i;
  logic [1:0]            d_size_i;
  logic                  d_unsigned_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [31:0]           d_wdata_i;
  logic                  d_rvalid_o;
  logic [31:0]           d_rdata_o;

  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [7:0]            mem_wdata_o;
  logic [7:0]            mem_rdata_i;

  modport slave (
    input  if_valid_i, if_addr_i,
    input  d_valid_i, d_we_i, d_size_i, d_unsigned_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i,
    output if_ready_o, if_rvalid_o, if_rdata_o,
    output d_ready_o, d_rvalid_o, d_rdata_o,
    output mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_valid_i, if_addr_i,
    output d_valid_i, d_we_i, d_size_i, d_unsigned_i, d_addr_i, d_wdata_i,
    output mem_rdata_i,
    input  if_ready_o, if_rvalid_o, if_rdata_o,
    input  d_ready_o, d_rvalid_o, d_rdata_o,
    input  mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_byte_seq_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a
// contested cycle goes to the other requester. After reset fetch wins ties.
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       enable_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (valid_i == 2'b11) begin
        grant_o = (last_q == REQ_D) ? 2'b01 : 2'b10;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = grant_o[REQ_D];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= REQ_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_byte_seq_ctrl.sv
// Shares one byte-wide bank between instruction fetch and load/store, splitting
// each access into little-endian byte cycles and extending load results.
module mem_byte_seq_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int DATA_DEPTH = 8192,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input logic                clk_i,
  input logic                rst_i,
  mem_byte_seq_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           buf_q, buf_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [1:0]  grant;
  logic        accept;
  logic [2:0]  nbytes;
  logic [1:0]  last_idx;
  logic [1:0]  idx_nxt;
  logic [31:0] buf_merged;

  mem_rr_arbiter u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   ({bus.d_valid_i, bus.if_valid_i}),
    .enable_i  ((state_q == ST_IDLE) && !rst_i),
    .advance_i (accept),
    .grant_o   (grant)
  );

  assign accept   = |grant;
  assign nbytes   = size_bytes(size_q);
  assign last_idx = 2'(nbytes - 3'd1);
  assign idx_nxt  = idx_q + 2'd1;

  // The byte arriving this cycle is merged so the final cycle can extend it directly.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign buf_merged[8*gi +: 8] = (!we_q && idx_q == 2'(gi)) ? bus.mem_rdata_i
                                                               : buf_q[8*gi +: 8];
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    rdata_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[REQ_D];
          if (grant[REQ_D]) begin
            base_d  = bus.d_addr_i;
            we_d    = bus.d_we_i;
            size_d  = bus.d_size_i;
            uns_d   = bus.d_unsigned_i;
            wdata_d = bus.d_wdata_i;
          end else begin
            base_d  = bus.if_addr_i;
            we_d    = 1'b0;
            size_d  = SZ_WORD;
            uns_d   = 1'b0;
            wdata_d = '0;
          end
          idx_d       = '0;
          buf_d       = '0;
          mem_addr_d  = base_d;
          mem_we_d    = we_d;
          mem_wdata_d = wdata_d[7:0];
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        buf_d = buf_merged;
        if (idx_q == last_idx) begin
          state_d     = ST_RESP;
          if_rvalid_d = (owner_q == REQ_IF);
          d_rvalid_d  = (owner_q == REQ_D);
          rdata_d     = we_q ? '0 : load_extend(buf_merged, size_q, uns_q);
        end else begin
          idx_d       = idx_nxt;
          mem_addr_d  = base_q + ADDR_WIDTH'(idx_nxt);
          mem_we_d    = we_q;
          mem_wdata_d = wdata_q[{idx_nxt, 3'b000} +: 8];
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_IF;
      base_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.if_ready_o  = grant[REQ_IF];
  assign bus.d_ready_o   = grant[REQ_D];
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.d_rvalid_o  = d_rvalid_q;
  assign bus.if_rdata_o  = if_rvalid_q ? rdata_q : '0;
  assign bus.d_rdata_o   = d_rvalid_q ? rdata_q : '0;
  // A reset cycle must not commit the byte that was scheduled for it.
  assign bus.mem_we_o    = mem_we_q & ~rst_i;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_seq_ctrl.sv
// Bench for mem_byte_seq_ctrl: byte bank model plus a transaction-level
// reference memory that computes expected load values and bank contents.
module tb_mem_byte_seq_ctrl;

  localparam int DEPTH = 8192;
  localparam int AW    = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_byte_seq_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  mem_byte_seq_ctrl #(.DATA_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  logic [7:0] bank    [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  assign bus.mem_rdata_i = bank[bus.mem_addr_o];
  always @(posedge clk) if (bus.mem_we_o) bank[bus.mem_addr_o] <= bus.mem_wdata_o;

  int checks   = 0;
  int failures = 0;

  function automatic int nbytes_of(input bit is_fetch, input logic [1:0] sz);
    if (is_fetch) return 4;
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [AW-1:0] addr, input int nb, input bit uns);
    logic [31:0] v = 0;
    for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[(int'(addr) + i) % DEPTH]) << (8 * i));
    if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic void model_store(input logic [AW-1:0] addr, input int nb, input logic [31:0] wd);
    for (int i = 0; i < nb; i++) ref_mem[(int'(addr) + i) % DEPTH] = 8'(wd >> (8 * i));
  endfunction

  task automatic idle_inputs();
    bus.if_valid_i = 1'b0; bus.if_addr_i = '0;
    bus.d_valid_i = 1'b0; bus.d_we_i = 1'b0; bus.d_size_i = 2'd0;
    bus.d_unsigned_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_req(input bit is_fetch, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [AW-1:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output bit wrong, output bit tmo);
    bit got;
    rd = '0; lat = 0; wrong = 1'b0; tmo = 1'b0;
    @(posedge clk); #1;
    if (is_fetch) begin
      bus.if_valid_i = 1'b1; bus.if_addr_i = addr;
    end else begin
      bus.d_valid_i = 1'b1; bus.d_we_i = we; bus.d_size_i = sz;
      bus.d_unsigned_i = uns; bus.d_addr_i = addr; bus.d_wdata_i = wd;
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_fetch ? bus.if_ready_o : bus.d_ready_o) begin got = 1'b1; break; end
    end
    if (!got) tmo = 1'b1;
    @(posedge clk); #1;
    bus.if_valid_i = 1'b0; bus.d_valid_i = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin
        lat = k; got = 1'b1;
        wrong = is_fetch ? (bus.if_rvalid_o !== 1'b1 || bus.d_rvalid_o !== 1'b0)
                         : (bus.d_rvalid_o !== 1'b1 || bus.if_rvalid_o !== 1'b0);
        rd = is_fetch ? bus.if_rdata_o : bus.d_rdata_o;
        break;
      end
    end
    if (!got) tmo = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.if_valid_i = 1'b1; bus.d_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.if_ready_o !== 1'b0 || bus.d_ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_ready got if=%b d=%b want 0 0", bus.if_ready_o, bus.d_ready_o);
    end
    checks++;
    if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_we_o} !== 3'b000 || bus.mem_addr_o !== '0 ||
        bus.mem_wdata_o !== 8'h00 || bus.if_rdata_o !== 32'h0 || bus.d_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got rv=%b%b we=%b addr=%h wd=%h ird=%h drd=%h want all 0",
               bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
               bus.if_rdata_o, bus.d_rdata_o);
    end
    @(posedge clk); #1;
    idle_inputs(); rst = 1'b0;
  endtask

  task automatic test_store_trace();
    bit ok;
    logic [31:0] wd;
    logic [AW-1:0] ea;
    logic [7:0] eb;
    wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.d_valid_i = 1'b1; bus.d_we_i = 1'b1; bus.d_size_i = 2'd2;
    bus.d_addr_i = 13'h0010; bus.d_wdata_i = wd;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.d_ready_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL sw_accept got ready=0 want 1"); end
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ea = 13'h0010 + 13'(c - 1);
      eb = 8'(wd >> (8 * (c - 1)));
      checks++;
      if (bus.mem_we_o !== 1'b1 || bus.mem_addr_o !== ea || bus.mem_wdata_o !== eb || bus.d_rvalid_o !== 1'b0) begin
        failures++;
        $display("FAIL sw_byte%0d got we=%b addr=%h wd=%h rv=%b want we=1 addr=%h wd=%h rv=0",
                 c, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.d_rvalid_o, ea, eb);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.d_rvalid_o !== 1'b1 || bus.d_rdata_o !== 32'h0 || bus.if_rvalid_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
      failures++;
      $display("FAIL sw_resp got drv=%b drd=%h irv=%b we=%b want 1 00000000 0 0",
               bus.d_rvalid_o, bus.d_rdata_o, bus.if_rvalid_o, bus.mem_we_o);
    end
    model_store(13'h0010, 4, wd);
    @(negedge clk);
    checks++;
    if (bus.d_rvalid_o !== 1'b0) begin failures++; $display("FAIL sw_resp_len got rv=1 want 0"); end
  endtask

  task automatic test_loads_directed();
    logic [1:0]    szs [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    bit            unss[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [AW-1:0] adrs[4] = '{13'h0013, 13'h0013, 13'h0012, 13'h0011};
    logic [31:0]   exps[4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h00DEADBE};
    logic [31:0] rd;
    int lat, nb;
    bit wrong, tmo;
    for (int i = 0; i < 4; i++) begin
      nb = nbytes_of(1'b0, szs[i]);
      do_req(1'b0, 1'b0, szs[i], unss[i], adrs[i], 32'h0, rd, lat, wrong, tmo);
      checks++;
      if (rd !== exps[i]) begin
        failures++; $display("FAIL load%0d_data addr=%h got %h want %h", i, adrs[i], rd, exps[i]);
      end
      checks++;
      if (tmo || wrong || lat != nb + 1) begin
        failures++; $display("FAIL load%0d_timing got lat=%0d wrong=%b tmo=%b want lat=%0d", i, lat, wrong, tmo, nb + 1);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int lat;
    bit wrong, tmo;
    logic [AW-1:0] a [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    logic [7:0]    e [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 13'h1FFE, 32'h44332211, rd, lat, wrong, tmo);
    model_store(13'h1FFE, 4, 32'h44332211);
    checks++;
    if (tmo || wrong || lat != 5 || rd !== 32'h0) begin
      failures++; $display("FAIL wrap_resp got lat=%0d rd=%h wrong=%b tmo=%b want lat=5 rd=0", lat, rd, wrong, tmo);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bank[a[i]] !== e[i]) begin
        failures++; $display("FAIL wrap_byte addr=%h got %h want %h", a[i], bank[a[i]], e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [4];
    logic [31:0] rd, ex;
    int lat;
    bit wrong, tmo, ok, saw;
    exp_b[0] = 8'hDD; exp_b[1] = 8'hCC;
    exp_b[2] = ref_mem[13'h0022]; exp_b[3] = ref_mem[13'h0023];
    @(posedge clk); #1;
    bus.d_valid_i = 1'b1; bus.d_we_i = 1'b1; bus.d_size_i = 2'd2;
    bus.d_addr_i = 13'h0020; bus.d_wdata_i = 32'hAABBCCDD;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.d_ready_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || bus.mem_we_o !== 1'b0 || bus.d_ready_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_during got accept=%b we=%b ready=%b want 1 0 0", ok, bus.mem_we_o, bus.d_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.d_valid_i = 1'b1; bus.d_addr_i = 13'h0020; bus.d_size_i = 2'd2;
    @(negedge clk);
    checks++;
    if (bus.d_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %b want 1", bus.d_ready_o); end
    #1 bus.d_valid_i = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.d_rvalid_o || bus.if_rvalid_o) saw = 1'b1;
    end
    checks++;
    if (saw) begin failures++; $display("FAIL rst_mid_rvalid got rvalid=1 want 0"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bank[13'h0020 + 13'(i)] !== exp_b[i]) begin
        failures++; $display("FAIL rst_mid_byte addr=%h got %h want %h", 13'h0020 + 13'(i), bank[13'h0020 + 13'(i)], exp_b[i]);
      end
    end
    ref_mem[13'h0020] = 8'hDD; ref_mem[13'h0021] = 8'hCC;
    ex = model_load(13'h0020, 4, 1'b0);
    do_req(1'b0, 1'b0, 2'd2, 1'b0, 13'h0020, 32'h0, rd, lat, wrong, tmo);
    checks++;
    if (tmo || wrong || lat != 5 || rd !== ex) begin
      failures++; $display("FAIL rst_mid_next got rd=%h lat=%0d want rd=%h lat=5", rd, lat, ex);
    end
  endtask

  task automatic test_fetch_during_data();
    logic [AW-1:0] da, fa;
    logic [31:0] dex, fex;
    bit ok, got;
    int lat;
    da = 13'($urandom_range(0, DEPTH - 1));
    fa = 13'($urandom_range(0, DEPTH - 1));
    dex = model_load(da, 4, 1'b0);
    fex = model_load(fa, 4, 1'b0);
    @(posedge clk); #1;
    bus.d_valid_i = 1'b1; bus.d_we_i = 1'b0; bus.d_size_i = 2'd3; bus.d_addr_i = da;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.d_ready_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    idle_inputs();
    bus.if_valid_i = 1'b1; bus.if_addr_i = fa;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (!ok || bus.if_ready_o !== 1'b0) begin
        failures++; $display("FAIL busy_ready cycle=%0d got if_ready=%b accept=%b want 0 1", c, bus.if_ready_o, ok);
      end
      if (c == 5) begin
        checks++;
        if (bus.d_rvalid_o !== 1'b1 || bus.if_rvalid_o !== 1'b0 || bus.d_rdata_o !== dex) begin
          failures++; $display("FAIL busy_data_resp got rv=%b rd=%h want 1 %h", bus.d_rvalid_o, bus.d_rdata_o, dex);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.if_ready_o !== 1'b1) begin failures++; $display("FAIL fetch_grant got %b want 1", bus.if_ready_o); end
    @(posedge clk); #1;
    bus.if_valid_i = 1'b0;
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin lat = k; got = 1'b1; break; end
    end
    checks++;
    if (!got || lat != 5 || bus.if_rvalid_o !== 1'b1 || bus.d_rvalid_o !== 1'b0 || bus.if_rdata_o !== fex) begin
      failures++; $display("FAIL fetch_resp got lat=%0d rd=%h want lat=5 rd=%h", lat, bus.if_rdata_o, fex);
    end
  endtask

  task automatic set_rand_d();
    bus.d_valid_i = 1'b1;
    bus.d_we_i = 1'($urandom_range(0, 1));
    bus.d_size_i = 2'($urandom_range(0, 3));
    bus.d_unsigned_i = 1'($urandom_range(0, 1));
    bus.d_addr_i = 13'($urandom_range(0, DEPTH - 1));
    bus.d_wdata_i = $urandom;
  endtask

  task automatic test_arbitration();
    bit exp_port [$];
    logic [31:0] exp_data [$];
    bit p, g_if, g_d, pok;
    logic [31:0] e, obs;
    int grants, nf, nd, cyc, nb;
    apply_reset();
    @(posedge clk); #1;
    bus.if_valid_i = 1'b1; bus.if_addr_i = 13'($urandom_range(0, DEPTH - 1));
    set_rand_d();
    grants = 0; nf = 0; nd = 0; cyc = 0;
    while ((grants < 8 || exp_port.size() > 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.if_rvalid_o || bus.d_rvalid_o) begin
        checks++;
        if (exp_port.size() == 0) begin
          failures++; $display("FAIL arb_resp unexpected rvalid if=%b d=%b", bus.if_rvalid_o, bus.d_rvalid_o);
        end else begin
          p = exp_port.pop_front(); e = exp_data.pop_front();
          pok = p ? (bus.d_rvalid_o === 1'b1 && bus.if_rvalid_o === 1'b0)
                  : (bus.if_rvalid_o === 1'b1 && bus.d_rvalid_o === 1'b0);
          obs = p ? bus.d_rdata_o : bus.if_rdata_o;
          if (!pok || obs !== e) begin
            failures++; $display("FAIL arb_resp port=%0d got rv=%b%b rd=%h want rd=%h", p, bus.if_rvalid_o, bus.d_rvalid_o, obs, e);
          end
        end
      end
      g_if = bus.if_ready_o; g_d = bus.d_ready_o;
      @(posedge clk); #1;
      if (g_if || g_d) begin
        checks++;
        if ((g_if && g_d) || g_d != ((grants % 2) == 1)) begin
          failures++; $display("FAIL arb_grant n=%0d got if=%b d=%b want %s", grants, g_if, g_d, (grants % 2) == 1 ? "data" : "fetch");
        end
        grants++;
        if (g_if) begin
          exp_port.push_back(1'b0); exp_data.push_back(model_load(bus.if_addr_i, 4, 1'b0)); nf++;
          bus.if_addr_i = 13'($urandom_range(0, DEPTH - 1));
        end else begin
          nb = nbytes_of(1'b0, bus.d_size_i);
          exp_port.push_back(1'b1);
          if (bus.d_we_i) begin
            model_store(bus.d_addr_i, nb, bus.d_wdata_i); exp_data.push_back(32'h0);
          end else begin
            exp_data.push_back(model_load(bus.d_addr_i, nb, bus.d_unsigned_i));
          end
          nd++;
          set_rand_d();
        end
        if (grants >= 8) idle_inputs();
      end
    end
    checks++;
    if (grants != 8 || nf != 4 || nd != 4 || exp_port.size() != 0) begin
      failures++; $display("FAIL arb_fairness got grants=%0d fetch=%0d data=%0d pending=%0d want 8 4 4 0", grants, nf, nd, exp_port.size());
    end
  endtask

  task automatic test_random();
    bit is_f, we, uns, wrong, tmo;
    logic [1:0] sz;
    logic [AW-1:0] addr;
    logic [31:0] wd, ex, rd;
    int nb, lat, bad;
    for (int t = 0; t < 40; t++) begin
      is_f = 1'($urandom_range(0, 1));
      we   = !is_f && ($urandom_range(0, 1) == 1);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = 13'h1FF0 + 13'($urandom_range(0, 31));
      wd   = $urandom;
      nb   = nbytes_of(is_f, sz);
      if (we) begin model_store(addr, nb, wd); ex = 32'h0; end
      else ex = model_load(addr, nb, is_f ? 1'b0 : uns);
      do_req(is_f, we, sz, uns, addr, wd, rd, lat, wrong, tmo);
      checks++;
      if (tmo || wrong || lat != nb + 1) begin
        failures++; $display("FAIL rand%0d_timing f=%b we=%b sz=%0d got lat=%0d wrong=%b tmo=%b want lat=%0d", t, is_f, we, sz, lat, wrong, tmo, nb + 1);
      end
      checks++;
      if (rd !== ex) begin
        failures++; $display("FAIL rand%0d_data f=%b we=%b sz=%0d u=%b addr=%h got %h want %h", t, is_f, we, sz, uns, addr, rd, ex);
      end
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (bank[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bank_contents got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      bank[i] = b;
      ref_mem[i] = b;
    end
    bank[13'h0014] = 8'h00;
    ref_mem[13'h0014] = 8'h00;
    test_reset();
    test_store_trace();
    test_loads_directed();
    test_wrap();
    test_reset_mid();
    test_fetch_during_data();
    test_arbitration();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
